// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU: op codes, sequencer states and flag bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    PASS_B = 3'b000,
    ADD    = 3'b010,
    SUB    = 3'b011,
    AND    = 3'b100,
    ORN    = 3'b101,
    XOR    = 3'b110
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == ADD) || (op == SUB);
  endfunction

endpackage

// File: rtl/bit_alu_wo_flag.sv
// One-bit ALU cell: result bit and carry-out only; flags are built by the sequencer.
module bit_alu_wo_flag
  import alu_pkg::*;
(
  input  logic [2:0] op_i,
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  output logic       r_o,
  output logic       c_o
);

  always_comb begin
    r_o = 1'b0;
    c_o = 1'b0;
    case (op_i)
      PASS_B: r_o = b_i;
      // SUB arrives with b already inverted and carry seeded to 1, so it is an add here
      ADD, SUB: begin
        r_o = a_i ^ b_i ^ c_i;
        c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
      end
      AND:     r_o = a_i & b_i;
      ORN:     r_o = a_i | ~b_i;
      XOR:     r_o = a_i ^ b_i;
      default: r_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ALU sequencer: feeds the 1-bit cell LSB-first for WIDTH cycles,
// assembles the result and derives N/Z/C/V, with valid/ready on both sides.
module bit_serial_alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  alu_flags_t       flags_q, flags_d;

  logic cell_r;
  logic cell_c;
  logic carry_msb;

  bit_alu_wo_flag u_cell (
    .op_i (op_q),
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .c_i  (carry_q),
    .r_o  (cell_r),
    .c_o  (cell_c)
  );

  // On the last bit the carry register holds the carry into the MSB
  assign carry_msb = carry_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = (op == SUB) ? ~b : b;
          op_d    = op;
          carry_d = (op == SUB);
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        result_d = {cell_r, result_q[WIDTH-1:1]};
        carry_d  = cell_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d   = DONE;
          flags_d.n = cell_r;
          flags_d.z = ~|result_d;
          flags_d.c = is_arith(op_q) & cell_c;
          flags_d.v = is_arith(op_q) & (carry_msb ^ cell_c);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flag_n    = flags_q.n;
  assign flag_z    = flags_q.z;
  assign flag_c    = flags_q.c;
  assign flag_v    = flags_q.v;

endmodule
